reg_file_ckpt: RTL and testbench

REG_FILE_CKPT -- requirements
Module: reg_file_ckpt

---
 rtl/reg_file_ckpt.sv | 78 +++++++
 tb/tb_reg_file_ckpt.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_ckpt.sv
// Two-port register file with a shadow bank.
// Snapshot and restore happen in one cycle.
module reg_file_ckpt #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_a,
  output logic [WIDTH-1:0]  rdata_b,
  input  logic              ckpt,
  input  logic              rstr,
  output logic              ckpt_valid,
  output logic              rstr_done
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] live   [DEPTH];
  logic [WIDTH-1:0] shadow [DEPTH];
  logic             rstr_ok;
  logic             wr_ok;
  logic             waddr_zero;

  assign rstr_ok    = rstr & ckpt_valid;
  assign waddr_zero = (ZERO_REG != 0) && (waddr == '0);
  assign wr_ok      = we & ~clr & ~rstr_ok & ~waddr_zero;

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        live[i]   <= '0;
        shadow[i] <= '0;
      end
      ckpt_valid <= 1'b0;
      rstr_done  <= 1'b0;
    end else if (rstr_ok) begin
      // restore wins over both a checkpoint and a write
      for (int i = 0; i < DEPTH; i++)
        live[i] <= shadow[i];
      rstr_done <= 1'b1;
    end else begin
      rstr_done <= 1'b0;
      if (ckpt) begin
        for (int i = 0; i < DEPTH; i++)
          shadow[i] <= live[i];
        ckpt_valid <= 1'b1;
      end
      if (wr_ok)
        live[waddr] <= wdata;
    end
  end

  function automatic logic [WIDTH-1:0] rd(
    input logic [ADDR_W-1:0] a
  );
    logic [WIDTH-1:0] v;
    v = live[a];
    if ((ZERO_REG != 0) && (a == '0))
      v = '0;
    else if ((BYPASS != 0) && wr_ok && (a == waddr))
      v = wdata;
    return v;
  endfunction

  always_comb begin
    rdata_a = rd(raddr_a);
    rdata_b = rd(raddr_b);
  end

endmodule

// File: tb/tb_reg_file_ckpt.sv
// Bench for reg_file_ckpt: two variants against one model.
// Index 1 = zero-reg + bypass, index 0 = neither.
module tb_reg_file_ckpt;

  logic        clk = 1'b0;
  logic        clr, we, ckpt, rstr;
  logic [4:0]  waddr, raddr_a, raddr_b;
  logic [31:0] wdata;
  logic [31:0] ra [2];
  logic [31:0] rb [2];
  logic        cv [2];
  logic        rd [2];

  int nchk  = 0;
  int nfail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  reg_file_ckpt #(.ZERO_REG(0), .BYPASS(0)) d0 (
    .clk(clk), .clr(clr), .we(we), .waddr(waddr),
    .wdata(wdata), .raddr_a(raddr_a), .raddr_b(raddr_b),
    .rdata_a(ra[0]), .rdata_b(rb[0]), .ckpt(ckpt),
    .rstr(rstr), .ckpt_valid(cv[0]), .rstr_done(rd[0])
  );

  reg_file_ckpt #(.ZERO_REG(1), .BYPASS(1)) d1 (
    .clk(clk), .clr(clr), .we(we), .waddr(waddr),
    .wdata(wdata), .raddr_a(raddr_a), .raddr_b(raddr_b),
    .rdata_a(ra[1]), .rdata_b(rb[1]), .ckpt(ckpt),
    .rstr(rstr), .ckpt_valid(cv[1]), .rstr_done(rd[1])
  );

  // behavioural model: register contents as plain arrays
  logic [31:0] ml [2][32];
  logic [31:0] ms [2][32];
  bit mv = 1'b0;
  bit md = 1'b0;

  always @(posedge clk) begin
    if (clr) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 32; i++) begin
          ml[k][i] = 0;
          ms[k][i] = 0;
        end
      mv = 0;
      md = 0;
    end else if (rstr && mv) begin
      ml = ms;
      md = 1;
    end else begin
      md = 0;
      if (ckpt) begin
        ms = ml;
        mv = 1;
      end
      for (int k = 0; k < 2; k++)
        if (we && !(k == 1 && waddr == 0))
          ml[k][waddr] = wdata;
    end
  end

  function automatic logic [31:0] exp_rd(int k, logic [4:0] a);
    if (k == 1 && a == 0) return 0;
    if (k == 1 && we && !clr && !(rstr && mv) && a == waddr)
      return wdata;
    return ml[k][a];
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("cmp_a%0d", k), ra[k], exp_rd(k, raddr_a));
        chk($sformatf("cmp_b%0d", k), rb[k], exp_rd(k, raddr_b));
        chk($sformatf("cmp_cv%0d", k), {31'd0, cv[k]}, {31'd0, mv});
        chk($sformatf("cmp_rd%0d", k), {31'd0, rd[k]}, {31'd0, md});
      end
    end
  end

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #2;
  endtask

  task automatic idle();
    we = 0; ckpt = 0; rstr = 0; clr = 0;
  endtask

  task automatic wr(logic [4:0] a, logic [31:0] d);
    we = 1; waddr = a; wdata = d;
  endtask

  initial begin
    idle();
    clr = 1; waddr = 0; wdata = 0;
    raddr_a = 5; raddr_b = 0;
    go();
    clr = 0;
    chk_en = 1;
    mid();
    chk("rst_a", ra[1], 0);
    chk("rst_cv", {31'd0, cv[1]}, 0);
    for (int i = 0; i < 32; i++) begin
      raddr_a = i[4:0]; raddr_b = 5'(31 - i);
      go();
    end

    wr(5, 32'hDEADBEEF); raddr_a = 0; raddr_b = 0;
    go();
    idle(); raddr_a = 5; raddr_b = 5;
    mid();
    chk("wr_a", ra[1], 32'hDEADBEEF);
    chk("wr_b", rb[1], 32'hDEADBEEF);
    chk("wr_a0", ra[0], 32'hDEADBEEF);

    go();
    wr(0, 32'h1234);
    go();
    idle(); raddr_a = 0;
    mid();
    chk("zr_on", ra[1], 0);
    chk("zr_off", ra[0], 32'h1234);

    go();
    wr(7, 32'h1111);
    go();
    wr(7, 32'hA5A5); raddr_a = 7;
    mid();
    chk("byp_on", ra[1], 32'hA5A5);
    chk("byp_off_old", ra[0], 32'h1111);
    go();
    idle();
    mid();
    chk("byp_off_new", ra[0], 32'hA5A5);

    go();
    wr(3, 32'h11); raddr_a = 3;
    go();
    ckpt = 1; wr(3, 32'h22);
    go();
    ckpt = 0; wr(3, 32'h33);
    mid();
    chk("ck_live", ra[0], 32'h22);
    chk("ck_valid", {31'd0, cv[0]}, 1);
    go();
    we = 0; rstr = 1;
    mid();
    chk("pre_rstr", ra[0], 32'h33);
    go();
    rstr = 0;
    mid();
    chk("rstr_val", ra[0], 32'h11);
    chk("rstr_done", {31'd0, rd[1]}, 1);
    go();
    mid();
    chk("rstr_pulse", {31'd0, rd[1]}, 0);
    wr(3, 32'h44);
    go();
    rstr = 1; wr(3, 32'h99);
    go();
    idle();
    mid();
    chk("rstr2_a1", ra[1], 32'h11);
    chk("rstr2_a0", ra[0], 32'h11);

    wr(3, 32'h66);
    go();
    idle(); ckpt = 1; rstr = 1;
    go();
    idle();
    mid();
    chk("ckrs_val", ra[0], 32'h11);
    chk("ckrs_done", {31'd0, rd[0]}, 1);
    wr(3, 32'h77);
    go();
    idle(); rstr = 1;
    go();
    idle();
    mid();
    chk("ckrs_shadow", ra[0], 32'h11);

    ckpt = 1; clr = 1; raddr_b = 5;
    go();
    idle();
    mid();
    chk("clr_cv", {31'd0, cv[0]}, 0);
    chk("clr_a", ra[0], 0);
    chk("clr_b", rb[0], 0);

    rstr = 1; wr(4, 32'h55); raddr_a = 4;
    go();
    idle();
    mid();
    chk("nosnap_a", ra[0], 32'h55);
    chk("nosnap_done", {31'd0, rd[0]}, 0);

    ckpt = 1; rstr = 1;
    go();
    idle();
    mid();
    chk("both_nov_cv", {31'd0, cv[1]}, 1);
    chk("both_nov_rd", {31'd0, rd[1]}, 0);

    go();
    ckpt = 1;
    go();
    idle(); clr = 1;
    go();
    idle();
    mid();
    chk("mid_clr_cv", {31'd0, cv[0]}, 0);

    for (int i = 0; i < 300; i++) begin
      we = 1'($urandom);
      waddr = 5'($urandom_range(0, 7));
      wdata = $urandom;
      raddr_a = 5'($urandom_range(0, 7));
      raddr_b = waddr;
      ckpt = ($urandom_range(0, 9) == 0);
      rstr = ($urandom_range(0, 7) == 0);
      clr = ($urandom_range(0, 60) == 0);
      go();
    end
    idle();
    go();
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
